// File: rtl/log_ram_capture.sv
// Multi-channel log capture RAM: run-armed capture into one word per sample, sliced readback.
// Optional decimation of accepted samples is enabled with `define LOG_DECIM_EN.
module log_ram_capture #(
    parameter int NB_DATA  = 16,
    parameter int N_CH     = 2,
    parameter int NB_ADDR  = 11,
    parameter int NB_SEL   = 1,
    parameter int NB_DECIM = 8
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_run,
    input  logic                      i_valid,
    input  logic [N_CH*NB_DATA-1:0]   i_data,
    input  logic [NB_ADDR-1:0]        i_rd_addr,
    input  logic [NB_SEL-1:0]         i_rd_sel,
`ifdef LOG_DECIM_EN
    input  logic [NB_DECIM-1:0]       i_decim,
`endif
    output logic [NB_DATA-1:0]        o_rd_data,
    output logic                      o_busy,
    output logic                      o_full,
    output logic [NB_ADDR-1:0]        o_wr_ptr
);

    localparam int DEPTH = 2 ** NB_ADDR;

    if (NB_DECIM < 1 || (2 ** NB_SEL) < N_CH) begin : g_bad_params
        $error("log_ram_capture: NB_SEL too narrow for N_CH or NB_DECIM < 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_run_d;
    logic                      r_busy;
    logic                      r_full;
    logic [NB_ADDR-1:0]        r_wr_ptr;
    logic [NB_DATA-1:0]        r_rd_data;
    logic [N_CH*NB_DATA-1:0]   r_mem [DEPTH];

    logic                      w_arm;
    logic                      w_start;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_busy_next;
    logic [N_CH*NB_DATA-1:0]   w_rd_word;
    logic [NB_DATA-1:0]        w_rd_slice;

    assign w_arm  = i_run & ~r_run_d;
    assign w_last = (r_wr_ptr == NB_ADDR'(DEPTH - 1));

`ifdef LOG_DECIM_EN
    logic [NB_DECIM-1:0] r_decim_cnt;
    logic                w_decim_ok;

    assign w_decim_ok = (r_decim_cnt == '0);

    // Compare with >= so a live shrink of i_decim still wraps promptly.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_decim_cnt <= '0;
        end else if (w_start) begin
            r_decim_cnt <= '0;
        end else if (r_state == S_CAPTURE && i_valid) begin
            r_decim_cnt <= (r_decim_cnt >= i_decim) ? '0 : r_decim_cnt + NB_DECIM'(1);
        end
    end
`else
    logic w_decim_ok;
    assign w_decim_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Filling the last address wins over an abort in the same cycle: o_full is still set.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_arm) w_next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_accept && w_last) w_next_state = i_run ? S_FULL : S_IDLE;
                else if (!i_run)        w_next_state = S_IDLE;
            end
            S_FULL: begin
                if (!i_run) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_start     = (r_state == S_IDLE) && w_arm;
        w_accept    = (r_state == S_CAPTURE) && i_valid && w_decim_ok;
        w_busy_next = (w_next_state == S_CAPTURE);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_run_d  <= 1'b0;
            r_busy   <= 1'b0;
            r_full   <= 1'b0;
            r_wr_ptr <= '0;
        end else begin
            r_run_d <= i_run;
            r_busy  <= w_busy_next;
            if (w_start) begin
                r_wr_ptr <= '0;
                r_full   <= 1'b0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + NB_ADDR'(1);
                if (w_last) r_full <= 1'b1;
            end
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (w_accept) r_mem[r_wr_ptr] <= i_data;
    end

    always_comb begin
        w_rd_word  = r_mem[i_rd_addr];
        w_rd_slice = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_rd_sel == NB_SEL'(k)) w_rd_slice = w_rd_word[k*NB_DATA +: NB_DATA];
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_slice;
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_busy    = r_busy;
    assign o_full    = r_full;
    assign o_wr_ptr  = r_wr_ptr;

endmodule

// File: tb/tb_log_ram_capture.sv
// Bench for log_ram_capture (NB_ADDR=4, N_CH=2, NB_SEL=2): directed scenarios plus a
// randomized run checked every cycle against a behavioural capture model.
module tb_log_ram_capture;

    localparam int NB_DATA  = 16;
    localparam int N_CH     = 2;
    localparam int NB_ADDR  = 4;
    localparam int NB_SEL   = 2;
    localparam int NB_DECIM = 8;
    localparam int DEPTH    = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     run;
    logic                     vld;
    logic [N_CH*NB_DATA-1:0]  data;
    logic [NB_ADDR-1:0]       rd_addr;
    logic [NB_SEL-1:0]        rd_sel;
    logic [NB_DECIM-1:0]      decim;
    logic [NB_DATA-1:0]       o_rd_data;
    logic                     o_busy;
    logic                     o_full;
    logic [NB_ADDR-1:0]       o_wr_ptr;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model: capture flag, full flag, pointer, memory image
    bit          m_capt, m_infull, m_full, m_run_d, m_rd_known;
    int          m_ptr, m_cnt;
    logic [31:0] m_mem [DEPTH];
    bit          m_written [DEPTH];
    logic [15:0] m_rd;

    always #5 clk = ~clk;

    log_ram_capture #(
        .NB_DATA(NB_DATA), .N_CH(N_CH), .NB_ADDR(NB_ADDR), .NB_SEL(NB_SEL), .NB_DECIM(NB_DECIM)
    ) dut (
        .clock     (clk),
        .i_reset   (rst),
        .i_run     (run),
        .i_valid   (vld),
        .i_data    (data),
        .i_rd_addr (rd_addr),
        .i_rd_sel  (rd_sel),
`ifdef LOG_DECIM_EN
        .i_decim   (decim),
`endif
        .o_rd_data (o_rd_data),
        .o_busy    (o_busy),
        .o_full    (o_full),
        .o_wr_ptr  (o_wr_ptr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the capture rules to the inputs seen at one rising edge.
    task automatic model_edge();
        bit accept;
        if (rst) begin
            m_capt = 0; m_infull = 0; m_full = 0; m_run_d = 0;
            m_ptr = 0; m_cnt = 0; m_rd = '0; m_rd_known = 1;
            return;
        end
        if (rd_sel >= N_CH) begin
            m_rd = '0;
            m_rd_known = 1;
        end else begin
            m_rd = 16'(m_mem[rd_addr] >> (NB_DATA * int'(rd_sel)));
            m_rd_known = m_written[rd_addr];
        end
        if (m_capt) begin
            accept = vld;
`ifdef LOG_DECIM_EN
            accept = vld && (m_cnt == 0);
            if (vld) m_cnt = (m_cnt >= int'(decim)) ? 0 : m_cnt + 1;
`endif
            if (accept) begin
                m_mem[m_ptr] = data;
                m_written[m_ptr] = 1;
                if (m_ptr == DEPTH - 1) begin
                    m_full = 1; m_ptr = 0; m_capt = 0; m_infull = run;
                end else begin
                    m_ptr++;
                end
            end
            if (!run) m_capt = 0;
        end else if (m_infull) begin
            if (!run) m_infull = 0;
        end else if (run && !m_run_d) begin
            m_capt = 1; m_ptr = 0; m_full = 0; m_cnt = 0;
        end
        m_run_d = run;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("busy", {31'b0, o_busy}, {31'b0, m_capt});
        check("full", {31'b0, o_full}, {31'b0, m_full});
        check("wr_ptr", {28'b0, o_wr_ptr}, m_ptr);
        if (m_rd_known) check("rd_data", {16'b0, o_rd_data}, {16'b0, m_rd});
    endtask

    task automatic drive(input bit r, input bit rn, input bit v, input logic [31:0] d);
        rst = r; run = rn; vld = v; data = d;
    endtask

    task automatic read_at(input int a, input int s);
        rd_addr = NB_ADDR'(a);
        rd_sel  = NB_SEL'(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        logic [15:0] k16;
        for (int i = 0; i < DEPTH; i++) m_written[i] = 0;
        decim = '0;
        drive(1, 1, 0, '0);
        read_at(0, 2);

        // Reset held three cycles with run high
        repeat (3) step();
        rst = 0;
        check("busy_rel_c1", {31'b0, o_busy}, 0);
        step();
        check("busy_rel_c2", {31'b0, o_busy}, 1);
        run = 0;
        step();

        // Abort after 7 samples, then re-arm
        run = 1;
        step();
        for (int k = 0; k < 7; k++) begin
            drive(0, 1, 1, $urandom);
            step();
        end
        drive(0, 0, 0, '0);
        step();
        check("abort_ptr", {28'b0, o_wr_ptr}, 7);
        check("abort_full", {31'b0, o_full}, 0);
        check("abort_busy", {31'b0, o_busy}, 0);
        run = 1;
        step();
        check("rearm_ptr", {28'b0, o_wr_ptr}, 0);
        check("rearm_busy", {31'b0, o_busy}, 1);

        // Full capture: 20 samples, channel 0 = k, channel 1 = ~k
        for (int k = 0; k < 20; k++) begin
            k16 = 16'(k);
            drive(0, 1, 1, {~k16, k16});
            step();
            if (k == 14) check("full_before16", {31'b0, o_full}, 0);
            if (k == 15) check("full_at16", {31'b0, o_full}, 1);
        end
        vld = 0;
        read_at(5, 1);
        step();
        check("rd_a5_s1", {16'b0, o_rd_data}, 32'h0000_FFFA);
        read_at(0, 0);
        step();
        check("rd_a0_kept", {16'b0, o_rd_data}, 0);

        // Readback: out-of-range select and one-cycle address latency
        read_at(5, 2);
        step();
        check("rd_sel2", {16'b0, o_rd_data}, 0);
        read_at(6, 0);
        check("rd_lat_before", {16'b0, o_rd_data}, 0);
        step();
        check("rd_lat_after", {16'b0, o_rd_data}, 6);

        // Re-arm after FULL overwrites from address 0
        run = 0;
        step();
        check("full_held", {31'b0, o_full}, 1);
        run = 1;
        step();
        check("full_cleared", {31'b0, o_full}, 0);
        drive(0, 1, 1, 32'hA5A5_5A5A);
        step();
        vld = 0;
        read_at(0, 1);
        step();
        check("rd_new_a0", {16'b0, o_rd_data}, 32'h0000_A5A5);
        run = 0;
        step();

`ifdef LOG_DECIM_EN
        // Decimation by 3: samples 0,3,6,9 land at addresses 0..3
        decim = 8'd2;
        run = 1;
        step();
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, 1, 32'(k));
            step();
        end
        vld = 0;
        check("decim_ptr", {28'b0, o_wr_ptr}, 4);
        for (int a = 0; a < 4; a++) begin
            read_at(a, 0);
            step();
            check("decim_rd", {16'b0, o_rd_data}, 32'(3 * a));
        end
        run = 0;
        step();
        decim = 8'($urandom_range(0, 3));
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (run) run = ($urandom_range(0, 29) != 0);
            else     run = ($urandom_range(0, 3) == 0);
            vld  = 1'($urandom_range(0, 1));
            data = $urandom;
            read_at($urandom_range(0, DEPTH - 1), $urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
